frame_loader: RTL and testbench



---
 rtl/frame_loader.sv | 247 ++++++++++++++++++++++++
 tb/tb_frame_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_loader.sv
// frame_loader: host-side frame ingest.
//
// Takes a byte-serial RGB stream (R, G, B per pixel) over a valid/ready handshake,
// assembles 24-bit pixels and writes each one into frame RAM in raster order at
// word address y*WIDTH + x + OFFSET. At most one pixel is written every four clocks.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle pulse that begins a frame load (ignored unless idle)
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   byte accepted on a cycle where in_valid && in_ready (registered)
//   wr_en      RAM write strobe, one cycle per pixel
//   wr_addr    RAM word address
//   wr_data    RAM write data {8'h00, R, G, B}
//   busy       high from the cycle after start is accepted until frame_done
//   frame_done one-cycle pulse once the frame is complete
//   error      checksum mismatch, sticky until the next accepted start
//
// Optional feature (define LOADER_CHECKSUM_EN): a 16-bit sum of all pixel bytes
// is compared against a two-byte trailer (low byte first) sent after the last
// pixel. Without it there are no trailer states and error is tied low.

module frame_loader #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 320,
    parameter int unsigned OFFSET = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        error
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GET_R   = 3'd1;
    localparam logic [2:0] GET_G   = 3'd2;
    localparam logic [2:0] GET_B   = 3'd3;
    localparam logic [2:0] WRITE   = 3'd4;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CSUM_LO = 3'd5;
    localparam logic [2:0] CSUM_HI = 3'd6;
`endif
    localparam logic [2:0] DONE    = 3'd7;

    localparam logic [31:0] LAST_INDEX = 32'(WIDTH * HEIGHT - 1);
    localparam logic [31:0] LAST_X     = 32'(WIDTH - 1);
    localparam logic [31:0] BASE       = 32'(OFFSET);

    logic [2:0]  state_q, state_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  g_q, g_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] index_q, index_d;
    logic        in_ready_q, in_ready_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    logic [7:0]  exp_lo_q, exp_lo_d;
    logic        error_q, error_d;
`endif

    logic accept;
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        g_d          = g_q;
        x_d          = x_q;
        y_d          = y_q;
        index_d      = index_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
        exp_lo_d     = exp_lo_q;
        error_d      = error_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    index_d = '0;
                    busy_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
                    error_d = 1'b0;
`endif
                    state_d = GET_R;
                end
            end
            GET_R: begin
                if (accept) begin
                    r_d     = in_data;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q + 16'(in_data);
`endif
                    state_d = GET_G;
                end
            end
            GET_G: begin
                if (accept) begin
                    g_d     = in_data;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q + 16'(in_data);
`endif
                    state_d = GET_B;
                end
            end
            GET_B: begin
                // The write strobe is registered here so it lands in the cycle right
                // after the B byte is accepted; B goes straight into wr_data.
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = index_q + BASE;
                    wr_data_d = {8'h00, r_q, g_q, in_data};
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = csum_q + 16'(in_data);
`endif
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                index_d = index_q + 32'd1;
                if (x_q == LAST_X) begin
                    x_d = '0;
                    y_d = y_q + 32'd1;
                end else begin
                    x_d = x_q + 32'd1;
                end
                if (index_q == LAST_INDEX) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d      = CSUM_LO;
`else
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
`endif
                end else begin
                    state_d = GET_R;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM_LO: begin
                if (accept) begin
                    exp_lo_d = in_data;
                    state_d  = CSUM_HI;
                end
            end
            CSUM_HI: begin
                if (accept) begin
                    error_d      = ({in_data, exp_lo_q} != csum_q);
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered ready: high for the whole of every byte-accepting state.
        in_ready_d = (state_d == GET_R) || (state_d == GET_G) || (state_d == GET_B)
`ifdef LOADER_CHECKSUM_EN
                  || (state_d == CSUM_LO) || (state_d == CSUM_HI)
`endif
                  ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            r_q          <= '0;
            g_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            index_q      <= '0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
            exp_lo_q     <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            g_q          <= g_d;
            x_q          <= x_d;
            y_q          <= y_d;
            index_q      <= index_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
            exp_lo_q     <= exp_lo_d;
            error_q      <= error_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
`ifdef LOADER_CHECKSUM_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_frame_loader.sv
// Testbench for frame_loader on a 4x2 frame. The reference model is the raster
// rule itself: pixel k lands at (k / W) * W + (k % W) + OFF with data {0, R, G, B}.
// Build with LOADER_CHECKSUM_EN defined to also exercise the trailer check.

module tb_frame_loader;

    localparam int unsigned W   = 4;
    localparam int unsigned H   = 2;
    localparam int unsigned OFF = 0;
    localparam int unsigned N   = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        frame_done;
    logic        error;

    always #5 clk = ~clk;

    frame_loader #(
        .WIDTH (W),
        .HEIGHT(H),
        .OFFSET(OFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_done(frame_done),
        .error     (error)
    );

    int checks     = 0;
    int failures   = 0;
    int wr_count   = 0;
    int done_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Counts write strobes and done pulses across the whole run.
    always @(negedge clk) begin
        if (wr_en) wr_count++;
        if (frame_done) begin
            done_count++;
            check_eq("busy_low_at_done", 32'(busy), 32'd0);
        end
    end

    // Presents a byte after `gap` idle cycles and returns just after it is accepted.
    // in_valid is left high so the source keeps presenting through non-ready cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit seen = 1'b0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("handshake", 32'(seen), 32'd1);
        if (seen) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pixel(input int k, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input int gr, input int gg, input int gb);
        int c0;
        logic [31:0] exp_addr;
        exp_addr = 32'((k / W) * W + (k % W) + OFF);
        send_byte(r, gr);
        send_byte(g, gg);
        c0 = wr_count;
        send_byte(b, gb);
        @(negedge clk);
        #1;
        check_eq("wr_en_after_b", 32'(wr_en), 32'd1);
        check_eq("in_ready_in_write", 32'(in_ready), 32'd0);
        check_eq("wr_addr", wr_addr, exp_addr);
        check_eq("wr_data", wr_data, {8'h00, r, g, b});
        check_eq("one_write_per_pixel", 32'(wr_count - c0), 32'd1);
    endtask

    // mode 0: directed pattern, 1: random bytes and gaps, 2: 5-cycle stall before B,
    // 3: start pulsed mid-frame, 4: all bytes 0x01.
    task automatic run_frame(input int mode, input bit bad_csum);
        logic [15:0] sum;
        logic [7:0]  r, g, b;
        int          gr, gg, gb, w0, d0;
        bit          seen;
        logic        exp_err;
        sum  = 16'h0000;
        seen = 1'b0;
        in_valid = 1'b0;
        w0 = wr_count;
        d0 = done_count;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("error_cleared_by_start", 32'(error), 32'd0);
        for (int k = 0; k < int'(N); k++) begin
            gr = 0; gg = 0; gb = 0;
            r = 8'(k); g = 8'(k); b = 8'(k);
            if (k == 0 && mode != 1 && mode != 4) begin
                r = 8'h12; g = 8'h34; b = 8'h56;
            end
            if (mode == 1) begin
                r  = 8'($urandom);
                g  = 8'($urandom);
                b  = 8'($urandom);
                gr = int'($urandom_range(0, 3));
                gg = int'($urandom_range(0, 3));
                gb = int'($urandom_range(0, 3));
            end
            if (mode == 2 && k == 1) gb = 5;
            if (mode == 4) begin
                r = 8'h01; g = 8'h01; b = 8'h01;
            end
            if (mode == 3 && k == 2) begin
                in_valid = 1'b0;
                start = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                start = 1'b0;
                check_eq("busy_after_mid_start", 32'(busy), 32'd1);
            end
            send_pixel(k, r, g, b, gr, gg, gb);
            sum = sum + 16'(r) + 16'(g) + 16'(b);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (sum[7:0] + 8'd1) : sum[7:0], 0);
        send_byte(sum[15:8], 0);
        exp_err = bad_csum;
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (frame_done) seen = 1'b1;
        end
        check_eq("frame_done_seen", 32'(seen), 32'd1);
        check_eq("busy_low_with_done", 32'(busy), 32'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("done_pulses", 32'(done_count - d0), 32'd1);
        check_eq("frame_writes", 32'(wr_count - w0), 32'(N));
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("in_ready_idle", 32'(in_ready), 32'd0);
        check_eq("error_after_frame", 32'(error), 32'(exp_err));
        $display("frame mode %0d pixel byte sum 0x%04h", mode, sum);
    endtask

    task automatic check_all_low(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check_eq({tag, "_wr_addr"}, wr_addr, 32'd0);
        check_eq({tag, "_wr_data"}, wr_data, 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic reset_mid_frame();
        int w0;
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) send_pixel(k, 8'(k + 1), 8'(k + 2), 8'(k + 3), 0, 0, 0);
        send_byte(8'hAA, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_low("async_reset");
        w0 = wr_count;
        repeat (6) @(negedge clk);
        check_eq("no_write_in_reset", 32'(wr_count - w0), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_after_reset_busy", 32'(busy), 32'd0);
        check_eq("idle_after_reset_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_low("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame(0, 1'b0);
        run_frame(2, 1'b0);
        run_frame(3, 1'b0);
        reset_mid_frame();
        run_frame(0, 1'b0);
        for (int i = 0; i < 4; i++) run_frame(1, 1'b0);
        run_frame(4, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        run_frame(4, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        check_eq("error_sticky", 32'(error), 32'd1);
        run_frame(4, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
